secuenciador_filtro: RTL and testbench

SECUENCIADOR_FILTRO -- requirements
Module: secuenciador_filtro

---
 rtl/secuenciador_filtro.sv | 108 ++++++++++
 tb/tb_secuenciador_filtro.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_filtro.sv
// Filter sequencer: feeds one sample per PERIOD cycles to a filter,
// collects its result or flags a missed deadline.
module secuenciador_filtro #(
    parameter int WIDTH   = 25,
    parameter int PERIOD  = 16,
    parameter int TIMEOUT = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             rx,
    output logic [WIDTH-1:0] u,
    input  logic             rx_2,
    input  logic [WIDTH-1:0] y,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             timeout_err,
    output logic             busy
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] HO_C = CW'(PERIOD - 2);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        HOLDOFF
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] mdata_q, mdata_d;
    logic             mv_q, mv_d;
    logic             to_q, to_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            u_q     <= '0;
            mdata_q <= '0;
            mv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            u_q     <= u_d;
            mdata_q <= mdata_d;
            mv_q    <= mv_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        u_d     = u_q;
        mdata_d = mdata_q;
        mv_d    = 1'b0;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    u_d     = s_data;
                    cnt_d   = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A late finish can land exactly on the slot before the next strobe
                if (rx_2) begin
                    mdata_d = y;
                    mv_d    = 1'b1;
                    state_d = (cnt_q == HO_C) ? IDLE : HOLDOFF;
                end else if (cnt_q == TO_C) begin
                    to_d    = 1'b1;
                    state_d = (cnt_q == HO_C) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HO_C) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready     = rst && (state_q == IDLE);
    assign rx          = (state_q == STROBE);
    assign busy        = (state_q != IDLE);
    assign u           = u_q;
    assign m_data      = mdata_q;
    assign m_valid     = mv_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Directed bench for secuenciador_filtro: reset, single sample,
// deadline boundaries, timeout, back-to-back and mid-transaction reset.
module tb_secuenciador_filtro;

    localparam int W = 25;
    localparam int P = 16;
    localparam int T = 14;
    localparam logic [W-1:0] JUNK = 25'h1FFFFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         rx_2 = 1'b0;
    logic [W-1:0] s_data = '0;
    logic [W-1:0] y = '0;
    logic         s_ready, rx, m_valid, timeout_err, busy;
    logic [W-1:0] u, m_data;

    int checks = 0;
    int errors = 0;

    int           o_rx_cnt, o_mv_cnt, o_mv_cyc, o_to_cnt, o_to_cyc, o_next_rx;
    logic [W-1:0] o_u0, o_md_mv, o_md_end;
    logic         o_both;

    secuenciador_filtro #(.WIDTH(W), .PERIOD(P), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .rx(rx),
        .u(u),
        .rx_2(rx_2),
        .y(y),
        .m_valid(m_valid),
        .m_data(m_data),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] smp(input int i);
        return W'(i * 7 + 1);
    endfunction

    function automatic logic [W-1:0] res(input int i);
        return W'(i * 13 + 5) ^ 25'h1555555;
    endfunction

    task automatic drain(input string nm);
        for (int i = 0; i < 64; i++) begin
            if (busy === 1'b0) break;
            tick;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain busy got %b want 0", nm, busy);
        end
    endtask

    // Starts one sample from IDLE and observes cycles 0..P (cycle 0 = STROBE)
    task automatic do_txn(input logic [W-1:0] d, input int k,
                          input logic [W-1:0] yv, input int stray,
                          input bit hold, input logic [W-1:0] nd);
        o_rx_cnt = 0; o_mv_cnt = 0; o_mv_cyc = -1;
        o_to_cnt = 0; o_to_cyc = -1; o_next_rx = -1;
        o_both = 1'b0; o_md_mv = '0;
        s_valid = 1'b1;
        s_data  = d;
        tick;
        s_valid = hold;
        s_data  = nd;
        o_u0    = u;
        for (int c = 0; c <= P; c++) begin
            if (rx && c < P) o_rx_cnt++;
            if (rx && c > 0 && o_next_rx < 0) o_next_rx = c;
            if (m_valid) begin
                o_mv_cnt++;
                o_mv_cyc = c;
                o_md_mv  = m_data;
            end
            if (timeout_err) begin
                o_to_cnt++;
                o_to_cyc = c;
            end
            if (m_valid && timeout_err) o_both = 1'b1;
            rx_2 = (c == k) || (c == stray);
            y    = (c == k) ? yv : JUNK;
            tick;
        end
        rx_2     = 1'b0;
        s_valid  = 1'b0;
        o_md_end = m_data;
    endtask

    task automatic test_reset;
        s_valid = 1'b1;
        s_data  = 25'h0F0F0F0;
        tick;
        tick;
        checks++;
        if ({rx, m_valid, timeout_err, busy, s_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {rx, m_valid, timeout_err, busy, s_ready});
        end
        checks++;
        if (u !== '0) begin
            errors++;
            $display("FAIL reset_u got %h want 0", u);
        end
        checks++;
        if (m_data !== '0) begin
            errors++;
            $display("FAIL reset_mdata got %h want 0", m_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b want 1", s_ready);
        end
        tick;
        s_valid = 1'b0;
        checks++;
        if (rx !== 1'b1 || u !== 25'h0F0F0F0) begin
            errors++;
            $display("FAIL first_accept got rx=%b u=%h want rx=1 u=0f0f0f0", rx, u);
        end
        drain("reset");
    endtask

    task automatic test_single;
        do_txn(25'h0ABCDE, 5, 25'h1234567, -1, 1'b0, '0);
        checks++;
        if (o_u0 !== 25'h0ABCDE) begin
            errors++;
            $display("FAIL single_u got %h want 0abcde", o_u0);
        end
        checks++;
        if (o_rx_cnt != 1) begin
            errors++;
            $display("FAIL single_rx_cnt got %0d want 1", o_rx_cnt);
        end
        checks++;
        if (o_mv_cnt != 1 || o_mv_cyc != 6) begin
            errors++;
            $display("FAIL single_mvalid got cnt=%0d cyc=%0d want 1 at 6",
                     o_mv_cnt, o_mv_cyc);
        end
        checks++;
        if (o_md_mv !== 25'h1234567) begin
            errors++;
            $display("FAIL single_mdata got %h want 1234567", o_md_mv);
        end
        checks++;
        if (o_to_cnt != 0) begin
            errors++;
            $display("FAIL single_to got %0d want 0", o_to_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_boundary;
        do_txn(25'h0000111, T, 25'h0777777, -1, 1'b0, '0);
        checks++;
        if (o_mv_cnt != 1 || o_mv_cyc != T + 1) begin
            errors++;
            $display("FAIL edge_mvalid got cnt=%0d cyc=%0d want 1 at %0d",
                     o_mv_cnt, o_mv_cyc, T + 1);
        end
        checks++;
        if (o_to_cnt != 0 || o_md_end !== 25'h0777777) begin
            errors++;
            $display("FAIL edge_prio got to=%0d md=%h want 0 0777777",
                     o_to_cnt, o_md_end);
        end
        do_txn(25'h0000222, 3, 25'h0333333, 0, 1'b0, '0);
        checks++;
        if (o_mv_cnt != 1 || o_mv_cyc != 4 || o_md_end !== 25'h0333333) begin
            errors++;
            $display("FAIL strobe_ignore got cnt=%0d cyc=%0d md=%h want 1 4 0333333",
                     o_mv_cnt, o_mv_cyc, o_md_end);
        end
        do_txn(25'h0000333, 3, 25'h0444444, 10, 1'b0, '0);
        checks++;
        if (o_mv_cnt != 1 || o_md_end !== 25'h0444444) begin
            errors++;
            $display("FAIL holdoff_ignore got cnt=%0d md=%h want 1 0444444",
                     o_mv_cnt, o_md_end);
        end
    endtask

    task automatic test_timeout;
        do_txn(25'h00055AA, -1, '0, -1, 1'b1, 25'h000AA55);
        checks++;
        if (o_to_cnt != 1 || o_to_cyc != T + 1) begin
            errors++;
            $display("FAIL timeout_pulse got cnt=%0d cyc=%0d want 1 at %0d",
                     o_to_cnt, o_to_cyc, T + 1);
        end
        checks++;
        if (o_mv_cnt != 0 || o_both) begin
            errors++;
            $display("FAIL timeout_mvalid got cnt=%0d both=%b want 0 0",
                     o_mv_cnt, o_both);
        end
        checks++;
        if (o_md_end !== 25'h0444444) begin
            errors++;
            $display("FAIL timeout_mdata got %h want 0444444", o_md_end);
        end
        checks++;
        if (o_next_rx != P) begin
            errors++;
            $display("FAIL timeout_next_rx got %0d want %0d", o_next_rx, P);
        end
        drain("timeout");
    endtask

    task automatic test_back_to_back;
        int cyc  = 0;
        int last = -1;
        int nrx  = 0;
        int nmv  = 0;
        int nacc = 0;
        while (nmv < 1000 && cyc < 20000) begin
            if (rx) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != P) begin
                        errors++;
                        $display("FAIL b2b_spacing got %0d want %0d", cyc - last, P);
                    end
                end
                checks++;
                if (u !== smp(nrx)) begin
                    errors++;
                    $display("FAIL b2b_u[%0d] got %h want %h", nrx, u, smp(nrx));
                end
                last = cyc;
                nrx++;
            end
            if (m_valid) begin
                checks++;
                if (m_data !== res(nmv)) begin
                    errors++;
                    $display("FAIL b2b_mdata[%0d] got %h want %h", nmv, m_data, res(nmv));
                end
                nmv++;
            end
            rx_2    = (last >= 0) && (cyc - last == 3);
            y       = rx_2 ? res(nrx - 1) : JUNK;
            s_valid = (nacc < 1000);
            s_data  = smp(nacc);
            if (s_valid && s_ready) nacc++;
            tick;
            cyc++;
        end
        rx_2    = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (nmv != 1000 || nrx != 1000) begin
            errors++;
            $display("FAIL b2b_count got mv=%0d rx=%0d want 1000 1000", nmv, nrx);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid;
        s_valid = 1'b1;
        s_data  = 25'h0C0FFEE;
        tick;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b0;
        #1;
        checks++;
        if (rx !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL midreset got rx=%b busy=%b md=%h want 0 0 0",
                     rx, busy, m_data);
        end
        #2 rst = 1'b1;
        rx_2    = 1'b1;
        y       = 25'h0DEAD00;
        s_valid = 1'b1;
        s_data  = 25'h0BEEF11;
        tick;
        rx_2    = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (rx !== 1'b1 || u !== 25'h0BEEF11) begin
            errors++;
            $display("FAIL midreset_accept got rx=%b u=%h want 1 0beef11", rx, u);
        end
        checks++;
        if (m_valid !== 1'b0 || timeout_err !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL midreset_quiet got mv=%b to=%b md=%h want 0 0 0",
                     m_valid, timeout_err, m_data);
        end
        drain("midreset");
    endtask

    initial begin
        test_reset;
        test_single;
        test_boundary;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
